// File: rtl/csr_access_ctrl_pkg.sv
// rtl/csr_access_ctrl_pkg.sv - shared types, CSR addresses and funct3 encodings for csr_access_ctrl
package csr_access_ctrl_pkg;

    localparam int CSR_XLEN = 64;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_funct3_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP,
        ST_T_EPC,
        ST_T_CAUSE,
        ST_T_TVAL
    } csr_ctrl_state_t;

    localparam int N_IMPL = 13;
    localparam logic [11:0] IMPL_ADDRS [N_IMPL] = '{
        12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
        12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14
    };

    function automatic logic csr_is_implemented(input logic [11:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_IMPL; i++) begin
            if (IMPL_ADDRS[i] == addr) hit = 1'b1;
        end
        return hit;
    endfunction

    // 000 and 100 are the only unused encodings in the Zicsr space.
    function automatic logic funct3_ok(input logic [2:0] funct3);
        return funct3[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/csr_access_ctrl_alu.sv
// rtl/csr_access_ctrl_alu.sv - combinational read-modify-write value and write-suppress decision
module csr_access_ctrl_alu
    import csr_access_ctrl_pkg::*;
#(
    parameter int XLEN = CSR_XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] src,
    input  logic [4:0]      rs1,
    output logic [XLEN-1:0] new_val,
    output logic            write_suppress
);

    logic [XLEN-1:0] src_eff;

    always_comb begin
        src_eff        = funct3[2] ? {{(XLEN-5){1'b0}}, rs1} : src;
        new_val        = old_val;
        write_suppress = 1'b1;
        case (funct3)
            CSRRW, CSRRWI: begin
                new_val        = src_eff;
                write_suppress = 1'b0;
            end
            CSRRS, CSRRSI: begin
                new_val        = old_val | src_eff;
                write_suppress = (rs1 == 5'd0);
            end
            CSRRC, CSRRCI: begin
                new_val        = old_val & ~src_eff;
                write_suppress = (rs1 == 5'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// rtl/csr_access_ctrl.sv - Zicsr read/write sequencer sharing the CSR write port with trap entry
// Optional read-only/unimplemented address check: CSR_ILLEGAL_CHECK_EN
module csr_access_ctrl
    import csr_access_ctrl_pkg::*;
#(
    parameter int XLEN = CSR_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_addr,
    input  logic [4:0]      req_rs1,
    input  logic [XLEN-1:0] req_src,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_epc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    output logic            trap_done,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            csr_we
);

    csr_ctrl_state_t state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [11:0]     addr_q, addr_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [XLEN-1:0] src_q, src_d;
    logic [XLEN-1:0] old_q, old_d;
    logic            ready_q, ready_d;
    logic [11:0]     raddr_q, raddr_d;
    logic [11:0]     waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic            resp_illegal_q, resp_illegal_d;
    logic            trap_done_q, trap_done_d;

    logic [XLEN-1:0] alu_new;
    logic            alu_suppress;
    logic            rd_illegal;

    csr_access_ctrl_alu #(.XLEN(XLEN)) u_alu (
        .funct3         (funct3_q),
        .old_val        (csr_rdata),
        .src            (src_q),
        .rs1            (rs1_q),
        .new_val        (alu_new),
        .write_suppress (alu_suppress)
    );

`ifdef CSR_ILLEGAL_CHECK_EN
    assign rd_illegal = !funct3_ok(funct3_q) || !csr_is_implemented(addr_q) ||
                        ((addr_q[11:10] == 2'b11) && !alu_suppress);
`else
    assign rd_illegal = !funct3_ok(funct3_q);
`endif

    // A pending trap masks ready so the pipeline never sees a request accepted and then stalled.
    assign req_ready    = ready_q && !trap_valid;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_illegal = resp_illegal_q;
    assign trap_done    = trap_done_q;
    assign csr_raddr    = raddr_q;
    assign csr_waddr    = waddr_q;
    assign csr_wdata    = wdata_q;
    assign csr_we       = we_q;

    always_comb begin
        state_d        = state_q;
        funct3_d       = funct3_q;
        addr_d         = addr_q;
        rs1_d          = rs1_q;
        src_d          = src_q;
        old_d          = old_q;
        ready_d        = 1'b0;
        raddr_d        = 12'd0;
        waddr_d        = 12'd0;
        wdata_d        = '0;
        we_d           = 1'b0;
        resp_valid_d   = 1'b0;
        resp_data_d    = '0;
        resp_illegal_d = 1'b0;
        trap_done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trap_valid) begin
                    state_d = ST_T_EPC;
                end else if (req_valid && req_ready) begin
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    rs1_d    = req_rs1;
                    src_d    = req_src;
                    state_d  = ST_RD;
                end
            end
            ST_RD: begin
                old_d   = csr_rdata;
                state_d = rd_illegal ? ST_RESP : ST_WR;
            end
            ST_WR:      state_d = ST_RESP;
            ST_RESP:    if (resp_ready) state_d = ST_IDLE;
            ST_T_EPC:   state_d = ST_T_CAUSE;
            ST_T_CAUSE: state_d = ST_T_TVAL;
            ST_T_TVAL:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        case (state_d)
            ST_IDLE: ready_d = 1'b1;
            ST_RD:   raddr_d = addr_d;
            ST_WR: begin
                waddr_d = addr_q;
                wdata_d = alu_new;
                we_d    = !alu_suppress;
            end
            ST_RESP: begin
                resp_valid_d   = 1'b1;
                resp_data_d    = old_d;
                resp_illegal_d = (state_q == ST_RD) ? rd_illegal : resp_illegal_q;
            end
            ST_T_EPC: begin
                waddr_d = CSR_MEPC;
                wdata_d = trap_epc;
                we_d    = 1'b1;
            end
            ST_T_CAUSE: begin
                waddr_d = CSR_MCAUSE;
                wdata_d = trap_cause;
                we_d    = 1'b1;
            end
            ST_T_TVAL: begin
                waddr_d     = CSR_MTVAL;
                wdata_d     = trap_tval;
                we_d        = 1'b1;
                trap_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            funct3_q       <= 3'd0;
            addr_q         <= 12'd0;
            rs1_q          <= 5'd0;
            src_q          <= '0;
            old_q          <= '0;
            ready_q        <= 1'b0;
            raddr_q        <= 12'd0;
            waddr_q        <= 12'd0;
            wdata_q        <= '0;
            we_q           <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_illegal_q <= 1'b0;
            trap_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            funct3_q       <= funct3_d;
            addr_q         <= addr_d;
            rs1_q          <= rs1_d;
            src_q          <= src_d;
            old_q          <= old_d;
            ready_q        <= ready_d;
            raddr_q        <= raddr_d;
            waddr_q        <= waddr_d;
            wdata_q        <= wdata_d;
            we_q           <= we_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_illegal_q <= resp_illegal_d;
            trap_done_q    <= trap_done_d;
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb/tb_csr_access_ctrl.sv - scoreboard bench for csr_access_ctrl with a CSR file model
module tb_csr_access_ctrl;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_funct3 = 3'd0;
    logic [11:0]     req_addr = 12'd0;
    logic [4:0]      req_rs1 = 5'd0;
    logic [XLEN-1:0] req_src = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] resp_data;
    logic            resp_illegal;
    logic            trap_valid = 1'b0;
    logic [XLEN-1:0] trap_epc = '0, trap_cause = '0, trap_tval = '0;
    logic            trap_done;
    logic [11:0]     csr_raddr;
    logic [XLEN-1:0] csr_rdata;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_we;

    csr_access_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_rs1(req_rs1), .req_src(req_src),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_illegal(resp_illegal),
        .trap_valid(trap_valid), .trap_epc(trap_epc), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .trap_done(trap_done),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_we(csr_we)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CSR file the DUT talks to, and the bench's own expectation of its contents.
    logic [XLEN-1:0] file_m [0:4095];
    logic [XLEN-1:0] ref_m  [0:4095];
    assign csr_rdata = file_m[csr_raddr];
    always @(posedge clk) if (csr_we) file_m[csr_waddr] <= csr_wdata;

    typedef struct { logic [11:0] addr; logic [63:0] data; int cyc; bit done; } wr_t;
    typedef struct { logic [63:0] data; bit ill; } rs_t;
    wr_t wq[$];
    rs_t rq[$];
    wr_t w;
    rs_t r;

    int checks = 0;
    int failures = 0;
    bit hold = 1'b0;
    bit in_reset = 1'b1;
    bit prev_stall = 1'b0;
    logic [63:0] prev_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        resp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (in_reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("resp_hold_valid", resp_valid, 1'b1);
                chk("resp_hold_data", resp_data, prev_data);
            end
            if (csr_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_we", csr_we, 1'b0);
                end else begin
                    w = wq.pop_front();
                    chk("waddr", csr_waddr, w.addr);
                    chk("wdata", csr_wdata, w.data);
                    chk("wcycle", cyc, w.cyc);
                    chk("trap_done", trap_done, w.done);
                end
            end else if (trap_done) begin
                chk("trap_done_without_we", trap_done, 1'b0);
            end
            if (resp_valid && resp_ready) begin
                if (rq.size() == 0) begin
                    chk("unexpected_resp", resp_valid, 1'b0);
                end else begin
                    r = rq.pop_front();
                    chk("resp_data", resp_data, r.data);
                    chk("resp_illegal", resp_illegal, r.ill);
                end
            end
            prev_stall = resp_valid && !resp_ready;
            prev_data  = resp_data;
        end
    end

    function automatic bit tb_impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
            12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b0);
        chk({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk({tag, "_resp_data"}, resp_data, 64'd0);
        chk({tag, "_resp_illegal"}, resp_illegal, 1'b0);
        chk({tag, "_trap_done"}, trap_done, 1'b0);
        chk({tag, "_csr_we"}, csr_we, 1'b0);
        chk({tag, "_csr_waddr"}, csr_waddr, 12'd0);
        chk({tag, "_csr_wdata"}, csr_wdata, 64'd0);
        chk({tag, "_csr_raddr"}, csr_raddr, 12'd0);
    endtask

    // mode 0: normal; mode 1: hold resp_ready low, then reset in RESP
    task automatic do_instr(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                            input logic [63:0] src, input bit with_trap, input int mode);
        int n;
        int c;
        int td_cyc;
        logic [63:0] old, srcv, nv, e, ca, tv;
        bit supp, ill;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin chk("timeout_idle", req_ready, 1'b1); return; end
        if (with_trap) begin
            e  = {$urandom, $urandom};
            ca = {32'd0, $urandom};
            tv = {$urandom, $urandom};
            trap_epc = e; trap_cause = ca; trap_tval = tv; trap_valid = 1'b1;
            c = cyc;
            wq.push_back('{12'h341, e, c + 1, 1'b0});
            wq.push_back('{12'h342, ca, c + 2, 1'b0});
            wq.push_back('{12'h343, tv, c + 3, 1'b1});
            ref_m[12'h341] = e; ref_m[12'h342] = ca; ref_m[12'h343] = tv;
        end
        req_valid = 1'b1; req_funct3 = f3; req_addr = addr; req_rs1 = rs1; req_src = src;
        if (with_trap) begin
            n = 0;
            while (!trap_done && n < 20) begin @(negedge clk); n++; end
            chk("trap_done_seen", trap_done, 1'b1);
            td_cyc = cyc;
            trap_valid = 1'b0;
            n = 0;
            while (!req_ready && n < 20) begin @(negedge clk); n++; end
            chk("accept_after_trap_cycle", cyc, td_cyc + 1);
        end
        if (mode == 1) hold = 1'b1;
        old  = ref_m[addr];
        srcv = f3[2] ? {59'd0, rs1} : src;
        case (f3[1:0])
            2'b01:   nv = srcv;
            2'b10:   nv = old | srcv;
            2'b11:   nv = old & ~srcv;
            default: nv = old;
        endcase
        supp = (f3[1:0] != 2'b01) && (rs1 == 5'd0);
        ill  = (f3[1:0] == 2'b00);
`ifdef CSR_ILLEGAL_CHECK_EN
        if (!ill && (!tb_impl(addr) || (addr[11:10] == 2'b11 && !supp))) ill = 1'b1;
`endif
        c = cyc;
        if (!ill && !supp) begin
            wq.push_back('{addr, nv, c + 2, 1'b0});
            ref_m[addr] = nv;
        end
        rq.push_back('{old, ill});
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (mode == 1) begin
            n = 0;
            while (!resp_valid && n < 20) begin @(negedge clk); n++; end
            repeat (5) @(negedge clk);
            chk("held_resp_valid", resp_valid, 1'b1);
            #2 in_reset = 1'b1;
            rst_n = 1'b0;
            #1 reset_checks("resp_reset");
            rq.delete();
            chk("no_pending_writes", wq.size(), 0);
            @(negedge clk);
            rst_n = 1'b1;
            hold = 1'b0;
            #2 in_reset = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("ready_after_resp_reset", req_ready, 1'b1);
        end else begin
            n = 0;
            while (rq.size() != 0 && n < 200) begin @(negedge clk); n++; end
            chk("resp_timeout", rq.size(), 0);
        end
    endtask

    logic [11:0] addr_tab [8] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h343, 12'hF14, 12'hC00, 12'h7C0};

    initial begin
        for (int i = 0; i < 4096; i++) begin file_m[i] = '0; ref_m[i] = '0; end
        file_m[12'h340] = 64'h1234; ref_m[12'h340] = 64'h1234;
        file_m[12'h300] = 64'h1800; ref_m[12'h300] = 64'h1800;
        file_m[12'hF14] = 64'h7;    ref_m[12'hF14] = 64'h7;
        repeat (3) @(negedge clk);
        reset_checks("por");
        rst_n = 1'b1;
        #2 in_reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1'b1);

        do_instr(3'b001, 12'h340, 5'd1, 64'hDEAD, 1'b0, 0);
        do_instr(3'b010, 12'h300, 5'd0, {$urandom, $urandom}, 1'b0, 0);
        do_instr(3'b001, 12'h340, 5'd2, 64'hFF, 1'b0, 0);
        do_instr(3'b111, 12'h340, 5'd5, 64'hFFFF, 1'b0, 0);
        do_instr(3'b001, 12'h340, 5'd2, 64'h0, 1'b0, 0);
        do_instr(3'b110, 12'h340, 5'd3, 64'hFFFF, 1'b0, 0);
        do_instr(3'b010, 12'h341, 5'd2, 64'h10, 1'b1, 0);
        do_instr(3'b001, 12'hF14, 5'd7, 64'h55, 1'b0, 0);
        do_instr(3'b000, 12'h340, 5'd4, 64'h99, 1'b0, 0);
        do_instr(3'b100, 12'h340, 5'd4, 64'h99, 1'b0, 0);
        do_instr(3'b001, 12'h305, 5'd1, 64'hABCD, 1'b0, 1);

        for (int k = 0; k < 40; k++) begin
            do_instr(3'($urandom_range(0, 7)), addr_tab[$urandom_range(0, 7)],
                     5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
                     {$urandom, $urandom}, ($urandom_range(0, 5) == 0), 0);
        end

        repeat (5) @(negedge clk);
        chk("write_queue_drained", wq.size(), 0);
        chk("resp_queue_drained", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/csr_access_ctrl.md
# csr_access_ctrl

Sequencer between the execute stage, the trap unit and the CSR register file. It turns one Zicsr instruction into a read cycle plus an optional write cycle on the file's read and write ports, and returns the old value to the pipeline. It shares the single write port with trap entry, which writes mepc, mcause and mtval in three back-to-back cycles.

## Interface
Parameters:
- XLEN, 64, data width; taken from pkg_parameters.

Ports. Reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CSR instruction request
- req_ready  out  1  high only in IDLE with no trap pending
- req_funct3  in  3  Zicsr funct3: 001 RW, 010 RS, 011 RC, 101/110/111 immediate forms
- req_addr  in  12  CSR address
- req_rs1  in  5  rs1 index, or uimm for immediate forms
- req_src  in  XLEN  rs1 register value; ignored for immediate forms
- resp_valid  out  1  old CSR value available
- resp_ready  in  1  pipeline accepts the response
- resp_data  out  XLEN  old CSR value, zero-extended to XLEN
- resp_illegal  out  1  illegal access flag (see Configuration)
- trap_valid  in  1  trap-entry request; level, held until trap_done
- trap_epc, trap_cause, trap_tval  in  XLEN each  values written on trap entry
- trap_done  out  1  one-cycle pulse after the mtval write
- csr_raddr  out  12  to the file's read port
- csr_rdata  in  XLEN  combinational read data from the file
- csr_waddr  out  12  to the file's write port
- csr_wdata  out  XLEN  write data
- csr_we  out  1  write enable, active-high

## Operation
- States: IDLE, RD, WR, RESP, T_EPC, T_CAUSE, T_TVAL.
- IDLE:
  - If trap_valid is high, go to T_EPC. Trap has priority over a simultaneous req_valid, which stays pending.
  - Otherwise, on req_valid && req_ready, latch funct3, addr, rs1 and src, then go to RD.
- RD:
  - csr_raddr = latched addr.
  - Capture csr_rdata into old_q.
  - Compute new_q:
    - RW: src.
    - RS: old | src.
    - RC: old & ~src.
    - For immediate forms, src = {(XLEN-5)'0, rs1}.
  - Go to WR.
- WR:
  - csr_we = 1 unless the write is suppressed.
  - Suppression applies to RS/RC, and their immediate forms, when rs1 == 0. RW never suppresses.
  - csr_waddr = addr, csr_wdata = new_q.
  - Go to RESP.
- RESP:
  - resp_valid = 1 and resp_data = old_q, held stable until resp_ready.
  - Go to IDLE on resp_ready.
- Trap path, one write per state:
  - T_EPC: csr_waddr 0x341, csr_wdata = trap_epc.
  - T_CAUSE: 0x342, trap_cause.
  - T_TVAL: 0x343, trap_tval, with trap_done = 1 in the same cycle.
  - Then IDLE.
- A trap raised while an instruction is in flight waits until IDLE. An instruction in flight is never aborted.
- Invalid funct3 (000 or 100): go to RESP directly with resp_illegal = 1 and no write.
- Outputs not named in the current state are 0.

## Timing
- Reset values: state IDLE; req_ready 0 during reset, 1 in the first IDLE cycle; every other output 0.
- Instruction latency: accept at edge N; RD during N..N+1; write lands at edge N+2; resp_valid from N+2. Minimum 4 cycles accept-to-accept.
- Trap entry: 3 cycles, one write per cycle. trap_done is high in the third.
- rst_n asserted in any state returns to IDLE immediately. Latched request and pending response are dropped; no partial trap sequence resumes.
- csr_rdata is sampled only in RD. The file's read must be combinational.

## Configuration
- CSR_ILLEGAL_CHECK_EN defined:
  - In RD, if addr[11:10] == 2'b11 (read-only space) and the write would not be suppressed, skip WR and go to RESP with resp_illegal = 1. resp_data is still old_q.
  - Addresses absent from pkg_csr also raise resp_illegal and are not written.
- Undefined: no checks, and resp_illegal is 1 only for invalid funct3. The file's own WARL/read-only filtering is the sole protection.

## Structure
- pkg_csr gains:
  - MEPC, MCAUSE and MTVAL address constants.
  - A funct3 enum: CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI.
  - The state typedef csr_ctrl_state_t.
  - The list of implemented addresses used by the illegal check.
- Sub-module csr_alu: combinational; inputs funct3, old, src, rs1; outputs new value and write_suppress.

## Test plan
- CSRRW addr 0x340 src 0xDEAD with the file holding 0x1234 -> resp_data 0x1234; one csr_we pulse with wdata 0xDEAD at accept+2.
- CSRRS rs1=0 on 0x300 -> resp_data equals the file value; csr_we stays 0 throughout.
- CSRRCI uimm 0x5 on 0x340 holding 0xFF -> wdata 0xFA; CSRRSI uimm 0x3 on 0x340 holding 0x0 -> wdata 0x3.
- trap_valid and req_valid asserted in the same IDLE cycle -> writes 0x341/0x342/0x343 on consecutive edges, trap_done in the third; the request is accepted next.
- resp_ready held low 5 cycles -> resp_valid and resp_data stable; rst_n pulsed in RESP -> all outputs 0 and state IDLE.
- With CSR_ILLEGAL_CHECK_EN, CSRRW to 0xF14 -> resp_illegal 1 and no csr_we; without the macro -> csr_we pulses and resp_illegal 0.
